// File: rtl/alarm_pkg.sv
// Shared definitions for the alarm controller: state encoding and digit limits.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RINGING = 2'd2,
    SNOOZE  = 2'd3
  } state_t;

  localparam logic [3:0] MAX_UNITS = 4'd9;
  localparam logic [2:0] MAX_TENS  = 3'd5;

endpackage

// File: rtl/alarm_setpoint.sv
// Alarm setpoint digits (minutes tens/units); each wraps independently, edits only in set mode.
module alarm_setpoint
  import alarm_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       set_alarm,
  input  logic       inc_min_units,
  input  logic       inc_min_tens,
  output logic [2:0] alarm_min_tens,
  output logic [3:0] alarm_min_units
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_min_tens  <= '0;
      alarm_min_units <= '0;
    end else if (set_alarm) begin
      // units never carries into tens: the two buttons edit their digit in isolation
      if (inc_min_units)
        alarm_min_units <= (alarm_min_units == MAX_UNITS) ? 4'd0 : alarm_min_units + 4'd1;
      if (inc_min_tens)
        alarm_min_tens <= (alarm_min_tens == MAX_TENS) ? 3'd0 : alarm_min_tens + 3'd1;
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// Alarm sequencer: compares setpoint against running mm:ss and drives ring/snooze/buzzer.
//   state   | meaning
//   IDLE    | alarm disabled or setpoint being edited
//   ARMED   | waiting for time to reach setpoint
//   RINGING | buzzer toggling each tick, RING_SECONDS ticks max
//   SNOOZE  | silent countdown of SNOOZE_SECONDS ticks, then rings again
module alarm_controller
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECONDS   = 60,   // 1..255
  parameter int unsigned SNOOZE_SECONDS = 120   // 1..255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [2:0] min_tens,
  input  logic [3:0] min_units,
  input  logic [2:0] sec_tens,
  input  logic [3:0] sec_units,
  input  logic       alarm_en,
  input  logic       set_alarm,
  input  logic       inc_min_units,
  input  logic       inc_min_tens,
  input  logic       snooze,
  input  logic       stop,
  output logic [2:0] alarm_min_tens,
  output logic [3:0] alarm_min_units,
  output logic       ringing,
  output logic       buzzer,
  output logic [1:0] state
);

  localparam logic [7:0] RING_LAST   = 8'(RING_SECONDS - 1);
  localparam logic [7:0] SNOOZE_LOAD = 8'(SNOOZE_SECONDS);

  state_t     state_q;
  logic [7:0] ring_cnt;
  logic [7:0] snooze_cnt;
  logic       match;
  logic       match_q;
  logic       trigger;

  alarm_setpoint u_setpoint (
    .clk             (clk),
    .reset           (reset),
    .set_alarm       (set_alarm),
    .inc_min_units   (inc_min_units),
    .inc_min_tens    (inc_min_tens),
    .alarm_min_tens  (alarm_min_tens),
    .alarm_min_units (alarm_min_units)
  );

  assign match = (min_tens == alarm_min_tens) && (min_units == alarm_min_units) &&
                 (sec_tens == 3'd0) && (sec_units == 4'd0);
  assign trigger = match && !match_q;

  // Reset value of 1 keeps 00:00 vs. setpoint 0:0 from firing straight out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) match_q <= 1'b1;
    else        match_q <= match;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      ring_cnt   <= '0;
      snooze_cnt <= '0;
      buzzer     <= 1'b0;
    end else if (!alarm_en) begin
      state_q <= IDLE;
      buzzer  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!set_alarm) state_q <= ARMED;
        end
        ARMED: begin
          if (set_alarm) begin
            state_q <= IDLE;
          end else if (trigger) begin
            state_q  <= RINGING;
            ring_cnt <= '0;
            buzzer   <= 1'b1;
          end
        end
        RINGING: begin
          if (stop) begin
            state_q <= ARMED;
            buzzer  <= 1'b0;
          end else if (snooze) begin
            state_q    <= SNOOZE;
            snooze_cnt <= SNOOZE_LOAD;
            buzzer     <= 1'b0;
          end else if (tick) begin
            if (ring_cnt == RING_LAST) begin
              state_q <= ARMED;
              buzzer  <= 1'b0;
            end else begin
              ring_cnt <= ring_cnt + 8'd1;
              buzzer   <= ~buzzer;
            end
          end
        end
        SNOOZE: begin
          if (stop) begin
            state_q <= ARMED;
          end else if (tick) begin
            if (snooze_cnt == 8'd1) begin
              state_q  <= RINGING;
              ring_cnt <= '0;
              buzzer   <= 1'b1;
            end else begin
              snooze_cnt <= snooze_cnt - 8'd1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          buzzer  <= 1'b0;
        end
      endcase
    end
  end

  assign state   = state_q;
  assign ringing = (state_q == RINGING);

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller: vector table for the main sequence, hand sequences for wraps and reset.
module tb_alarm_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [2:0] min_tens;
  logic [3:0] min_units;
  logic [2:0] sec_tens;
  logic [3:0] sec_units;
  logic       alarm_en, set_alarm, inc_min_units, inc_min_tens, snooze, stop;
  logic [2:0] alarm_min_tens;
  logic [3:0] alarm_min_units;
  logic       ringing, buzzer;
  logic [1:0] state;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [2:0] mt;
    logic [3:0] mu;
    logic [2:0] st;
    logic [3:0] su;
    logic       en, set, iu, it, sn, sp, tk;
    logic [1:0] e_state;
    logic       e_ring, e_buzz;
    logic [2:0] e_at;
    logic [3:0] e_au;
  } vec_t;

  vec_t vecs[$];

  alarm_controller #(.RING_SECONDS(4), .SNOOZE_SECONDS(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .tick            (tick),
    .min_tens        (min_tens),
    .min_units       (min_units),
    .sec_tens        (sec_tens),
    .sec_units       (sec_units),
    .alarm_en        (alarm_en),
    .set_alarm       (set_alarm),
    .inc_min_units   (inc_min_units),
    .inc_min_tens    (inc_min_tens),
    .snooze          (snooze),
    .stop            (stop),
    .alarm_min_tens  (alarm_min_tens),
    .alarm_min_units (alarm_min_units),
    .ringing         (ringing),
    .buzzer          (buzzer),
    .state           (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [2:0] mt, input logic [3:0] mu, input logic [2:0] st, input logic [3:0] su,
                     input logic en, input logic set, input logic iu, input logic it,
                     input logic sn, input logic sp, input logic tk,
                     input logic [1:0] es, input logic er, input logic eb,
                     input logic [2:0] eat, input logic [3:0] eau);
    vec_t v;
    v = '{mt, mu, st, su, en, set, iu, it, sn, sp, tk, es, er, eb, eat, eau};
    vecs.push_back(v);
  endtask

  task automatic pulse_units();
    inc_min_units = 1'b1; cyc(); inc_min_units = 1'b0;
  endtask

  task automatic pulse_tens();
    inc_min_tens = 1'b1; cyc(); inc_min_tens = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    tick = 0; min_tens = 0; min_units = 0; sec_tens = 0; sec_units = 0;
    alarm_en = 0; set_alarm = 0; inc_min_units = 0; inc_min_tens = 0; snooze = 0; stop = 0;

    //   mt mu st su en set iu it sn sp tk | state ring buzz at au
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0); // 0 arm at 00:00
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0); // 1 no false trigger
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0); // 2 set mode disarms
    add(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0,   0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0,   0, 0, 0, 1, 3); // 6 setpoint 13
    add(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 3); // 7 rearm
    add(1, 2, 5, 9, 1, 0, 0, 0, 0, 0, 1,   1, 0, 0, 1, 3); // 8 12:59
    add(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0,   2, 1, 1, 1, 3); // 9 13:00 -> ringing
    add(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 1,   2, 1, 0, 1, 3); // 10 tick 1
    add(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0,   2, 1, 0, 1, 3); // 11 no tick
    add(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 1,   2, 1, 1, 1, 3); // 12 tick 2
    add(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 1,   2, 1, 0, 1, 3); // 13 tick 3
    add(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 1,   1, 0, 0, 1, 3); // 14 tick 4 -> armed
    add(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 1,   1, 0, 0, 1, 3); // 15 held 13:00, no retrigger
    add(1, 3, 0, 1, 1, 0, 0, 0, 0, 0, 1,   1, 0, 0, 1, 3); // 16 13:01
    add(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0,   2, 1, 1, 1, 3); // 17 retrigger
    add(1, 3, 0, 0, 1, 0, 0, 0, 1, 0, 0,   3, 0, 0, 1, 3); // 18 snooze
    add(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 1,   3, 0, 0, 1, 3);
    add(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 1,   3, 0, 0, 1, 3);
    add(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 1,   2, 1, 1, 1, 3); // 21 3rd tick -> ringing
    add(1, 3, 0, 0, 1, 0, 0, 0, 0, 1, 0,   1, 0, 0, 1, 3); // 22 stop
    add(1, 3, 0, 1, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 3);
    add(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0,   2, 1, 1, 1, 3);
    add(1, 3, 0, 0, 1, 0, 0, 0, 1, 1, 0,   1, 0, 0, 1, 3); // 25 stop beats snooze
    add(1, 3, 0, 1, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 3);
    add(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0,   2, 1, 1, 1, 3);
    add(1, 3, 0, 0, 1, 1, 0, 0, 0, 0, 0,   2, 1, 1, 1, 3); // 28 set ignored while ringing
    add(1, 3, 0, 0, 1, 0, 0, 0, 1, 0, 0,   3, 0, 0, 1, 3);
    add(1, 3, 0, 1, 1, 0, 0, 0, 0, 0, 0,   3, 0, 0, 1, 3);
    add(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0,   3, 0, 0, 1, 3); // 31 trigger ignored in snooze
    add(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 3); // 32 alarm_en drop -> idle
    add(1, 3, 0, 0, 1, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 3);
    add(1, 3, 0, 0, 1, 0, 1, 1, 0, 0, 0,   1, 0, 0, 1, 3); // 34 edits ignored outside set mode

    #12 reset = 1'b1;
    #1;
    check("rst_state", 0, 8'(state), 8'd0);
    check("rst_at", 0, 8'(alarm_min_tens), 8'd0);
    check("rst_au", 0, 8'(alarm_min_units), 8'd0);
    check("rst_buzz", 0, 8'(buzzer), 8'd0);
    @(negedge clk);

    foreach (vecs[i]) begin
      min_tens = vecs[i].mt; min_units = vecs[i].mu;
      sec_tens = vecs[i].st; sec_units = vecs[i].su;
      alarm_en = vecs[i].en; set_alarm = vecs[i].set;
      inc_min_units = vecs[i].iu; inc_min_tens = vecs[i].it;
      snooze = vecs[i].sn; stop = vecs[i].sp; tick = vecs[i].tk;
      cyc();
      check("vec_state", i, 8'(state), 8'(vecs[i].e_state));
      check("vec_ring", i, 8'(ringing), 8'(vecs[i].e_ring));
      check("vec_buzz", i, 8'(buzzer), 8'(vecs[i].e_buzz));
      check("vec_at", i, 8'(alarm_min_tens), 8'(vecs[i].e_at));
      check("vec_au", i, 8'(alarm_min_units), 8'(vecs[i].e_au));
    end
    inc_min_units = 0; inc_min_tens = 0; snooze = 0; stop = 0; tick = 0;

    // setpoint 1:3 -> units up to 9, then wrap without touching tens
    set_alarm = 1'b1;
    for (int k = 0; k < 6; k++) pulse_units();
    check("wrap_u9", 0, 8'(alarm_min_units), 8'd9);
    pulse_units();
    check("wrap_u0", 0, 8'(alarm_min_units), 8'd0);
    check("wrap_u_tens", 0, 8'(alarm_min_tens), 8'd1);
    for (int k = 0; k < 4; k++) pulse_tens();
    check("wrap_t5", 0, 8'(alarm_min_tens), 8'd5);
    pulse_tens();
    check("wrap_t0", 0, 8'(alarm_min_tens), 8'd0);
    check("wrap_t_units", 0, 8'(alarm_min_units), 8'd0);
    inc_min_units = 1'b1; inc_min_tens = 1'b1; cyc();
    inc_min_units = 1'b0; inc_min_tens = 1'b0;
    check("both_t", 0, 8'(alarm_min_tens), 8'd1);
    check("both_u", 0, 8'(alarm_min_units), 8'd1);

    // arm with setpoint 11, hit 11:00, then reset asynchronously mid-ring
    set_alarm = 1'b0; min_tens = 0; min_units = 0; cyc();
    check("rearm", 0, 8'(state), 8'd1);
    min_tens = 1; min_units = 1; sec_tens = 0; sec_units = 0; cyc();
    check("ring11", 0, 8'(ringing), 8'd1);
    check("ring11_buzz", 0, 8'(buzzer), 8'd1);
    #3 reset = 1'b0;
    #1;
    check("async_state", 0, 8'(state), 8'd0);
    check("async_ring", 0, 8'(ringing), 8'd0);
    check("async_buzz", 0, 8'(buzzer), 8'd0);
    check("async_at", 0, 8'(alarm_min_tens), 8'd0);
    check("async_au", 0, 8'(alarm_min_units), 8'd0);
    #2 reset = 1'b1;
    cyc();
    check("post_rst_arm", 0, 8'(state), 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alarm_controller.md
Name: alarm_controller

Overview:
- Downstream consumer of the mm:ss digits produced by the system counter.
- Holds a user-editable alarm setpoint (minutes only: min_tens, min_units) and compares it against the running time.
- Sequences the alarm through arm, ring, snooze and stop, driving a buzzer output and the setpoint digits for the display stage.
- All time-based actions advance on the 1 Hz tick that also enables the counter.

Parameters:
RING_SECONDS, 60, ticks spent RINGING before automatic return to ARMED (must be 1..255)
SNOOZE_SECONDS, 120, ticks spent in SNOOZE before re-ringing (must be 1..255)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
tick  input  1  single-cycle 1 Hz enable pulse, same pulse that advances the counter
min_tens  input  3  current time minutes tens (0..5)
min_units  input  4  current time minutes units (0..9)
sec_tens  input  3  current time seconds tens (0..5)
sec_units  input  4  current time seconds units (0..9)
alarm_en  input  1  level; alarm function enabled
set_alarm  input  1  level; setpoint edit mode
inc_min_units  input  1  single-cycle debounced pulse; increment setpoint units
inc_min_tens  input  1  single-cycle debounced pulse; increment setpoint tens
snooze  input  1  single-cycle debounced pulse
stop  input  1  single-cycle debounced pulse
alarm_min_tens  output  3  setpoint tens, to display
alarm_min_units  output  4  setpoint units, to display
ringing  output  1  high in RINGING
buzzer  output  1  buzzer drive
state  output  2  IDLE=0, ARMED=1, RINGING=2, SNOOZE=3

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, setpoint 0:0, buzzer=0, ring/snooze counters=0, match_q=1.
- match_q=1 at reset suppresses a false trigger while time and setpoint are both 00:00.
- Setpoint edit occurs only while set_alarm=1.
  - inc_min_units wraps 9->0 without carrying into tens.
  - inc_min_tens wraps 5->0.
  - Simultaneous pulses: both fields update in the same cycle.
- Edit pulses are ignored when set_alarm=0.
- match (combinational) = min_tens==alarm_min_tens && min_units==alarm_min_units && sec_tens==0 && sec_units==0.
- match_q is registered each cycle.
- trigger = match && !match_q; fires once per occurrence, one cycle after the time digits reach the match value.
- Transition priority, highest first: reset, alarm_en=0, stop, snooze, timer expiry.
- IDLE -> ARMED when alarm_en=1 && set_alarm=0.
- ARMED:
  - -> IDLE if alarm_en=0 or set_alarm=1.
  - -> RINGING on trigger; ring counter loads 0; buzzer set to 1.
- RINGING:
  - Each tick increments the ring counter and toggles buzzer.
  - On the tick where the counter reaches RING_SECONDS-1: -> ARMED.
  - stop -> ARMED.
  - snooze -> SNOOZE, with snooze counter loaded with SNOOZE_SECONDS.
  - set_alarm=1 is ignored while ringing.
- SNOOZE:
  - Each tick decrements the snooze counter.
  - On the tick where the counter equals 1: -> RINGING (ring counter reloads 0, buzzer=1).
  - stop -> ARMED.
  - A trigger while in SNOOZE is ignored.
- Any state with alarm_en=0 -> IDLE in the next cycle.
- Outputs:
  - buzzer is forced 0 in every state other than RINGING.
  - ringing = (state==RINGING).
  - All outputs are registered, except ringing, which decodes from the state register.
- Latency: stop/snooze pulse to state change is 1 cycle; trigger to ringing=1 is 1 cycle.

Decomposition:
- Shared package alarm_pkg:
  - state encoding constants (IDLE, ARMED, RINGING, SNOOZE)
  - digit limits (MAX_UNITS=9, MAX_TENS=5)
- One sub-module, alarm_setpoint: the two wrapping digit registers with the edit-enable gate.
- FSM, counters and match logic stay in alarm_controller.

Test Plan:
- Reset, then alarm_en=1, time held 00:00 -> state ARMED, ringing stays 0; no false trigger.
- set_alarm=1, 3x inc_min_units, 1x inc_min_tens, set_alarm=0, alarm_en=1, time stepped to 13:00 -> alarm digits 1/3; ringing=1 one cycle after the match; buzzer toggles each tick.
- Ringing with RING_SECONDS=4 and no input, 4 ticks -> state returns to ARMED, buzzer=0; holding 13:00 does not re-trigger.
- Ringing, snooze pulse, SNOOZE_SECONDS=3 -> state SNOOZE, buzzer=0; after the 3rd tick state=RINGING; then stop -> ARMED.
- stop and snooze in the same cycle while RINGING -> ARMED (stop wins); alarm_en dropped in SNOOZE -> IDLE next cycle.
- Wrap check: inc_min_units from 9 -> 0 with tens unchanged; inc_min_tens from 5 -> 0; reset asserted mid-RINGING -> immediate IDLE, setpoint 0:0.
